// File: rtl/arr_pkg.sv
// Shared types and helpers for the arr_bank array-storage block.
//   host_state_t : host burst engine states
//   HOST_LOAD / HOST_DUMP : host_mode encodings
//   arr_addr_w() : address width for a given depth (never below 1)
package arr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DUMP = 2'd2,
    FIN  = 2'd3
  } host_state_t;

  localparam logic HOST_LOAD = 1'b0;
  localparam logic HOST_DUMP = 1'b1;

  function automatic int unsigned arr_addr_w(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/arr_mem.sv
// Single-port RAM with registered read data.
//   clk, rst_n : clock, synchronous active-low reset (clears read register only)
//   en, we     : access enable, write enable
//   addr       : word address
//   wdata      : write data
//   rdata      : read data, valid the cycle after a read access
module arr_mem
  import arr_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = arr_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array: contents survive reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register only updates on a read, so it holds while a consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/arr_bank.sv
// Array bank: one single-port RAM shared by NPORT kernel ports (fixed priority,
// lowest index wins) and a host burst engine (LOAD/DUMP over valid/ready).
//   controlArr       : 1 = host engine owns the RAM, 0 = kernel ports own it
//   host_start/mode/base/len : burst command, accepted in IDLE only
//   host_w*          : LOAD data stream; host_r* : DUMP data stream
//   host_busy/done/abort : engine status, done/abort are one-cycle pulses
//   k_req/we/addr/wdata  : kernel requests; k_grant is combinational
//   k_rvalid/k_rdata     : kernel read return, one cycle after the grant
module arr_bank
  import arr_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = arr_addr_w(DEPTH),
  parameter int unsigned NPORT  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     controlArr,
  input  logic                     host_start,
  input  logic                     host_mode,
  input  logic [ADDR_W-1:0]        host_base,
  input  logic [ADDR_W:0]          host_len,
  input  logic                     host_wvalid,
  output logic                     host_wready,
  input  logic [WIDTH-1:0]         host_wdata,
  output logic                     host_rvalid,
  input  logic                     host_rready,
  output logic [WIDTH-1:0]         host_rdata,
  output logic                     host_busy,
  output logic                     host_done,
  output logic                     host_abort,
  input  logic [NPORT-1:0]         k_req,
  input  logic [NPORT-1:0]         k_we,
  input  logic [NPORT*ADDR_W-1:0]  k_addr,
  input  logic [NPORT*WIDTH-1:0]   k_wdata,
  output logic [NPORT-1:0]         k_grant,
  output logic [NPORT-1:0]         k_rvalid,
  output logic [WIDTH-1:0]         k_rdata
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  host_state_t       state, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_d, done_d, abort_d, wready_d, rvalid_d;
  logic              load_acc, dump_iss;
  logic [NPORT-1:0]  k_rvalid_q;
  logic              found;

  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata, mem_rdata;

  // Burst address advances modulo DEPTH (DEPTH need not be a power of two).
  assign addr_inc = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : ADDR_W'(addr_q + ADDR_W'(1));

  // Host engine next-state and next-output logic.
  always_comb begin
    state_d  = state;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    rvalid_d = host_rvalid;
    load_acc = 1'b0;
    dump_iss = 1'b0;

    case (state)
      IDLE: begin
        if (host_start && controlArr) begin
          addr_d = host_base;
          cnt_d  = host_len;
          if (host_len == '0) begin
            state_d = FIN;
          end else if (host_mode == HOST_LOAD) begin
            state_d = LOAD;
          end else begin
            state_d = DUMP;
          end
        end
      end
      LOAD: begin
        if (host_wready && host_wvalid) begin
          load_acc = 1'b1;
          addr_d   = addr_inc;
          cnt_d    = CNT_W'(cnt_q - CNT_W'(1));
          if (cnt_q == CNT_W'(1)) begin
            state_d = FIN;
            done_d  = 1'b1;
          end
        end
      end
      DUMP: begin
        if (host_rvalid && host_rready) begin
          rvalid_d = 1'b0;
        end
        // The one-word slot is free if empty or draining this cycle.
        if (!host_rvalid || host_rready) begin
          if (cnt_q != '0) begin
            dump_iss = 1'b1;
            rvalid_d = 1'b1;
            addr_d   = addr_inc;
            cnt_d    = CNT_W'(cnt_q - CNT_W'(1));
          end else begin
            state_d = FIN;
            done_d  = 1'b1;
          end
        end
      end
      FIN: begin
        // Bursts enter FIN with done already raised; a zero-length burst
        // arrives with done low and raises it here.
        if (host_done) begin
          state_d = IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Losing ownership cancels any burst in flight.
    if (!controlArr && (state != IDLE) && !((state == FIN) && host_done)) begin
      state_d  = IDLE;
      abort_d  = 1'b1;
      done_d   = 1'b0;
      rvalid_d = 1'b0;
      load_acc = 1'b0;
      dump_iss = 1'b0;
    end

    busy_d   = (state_d != IDLE) && !done_d;
    wready_d = (state_d == LOAD);
  end

  // Host engine registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      host_busy   <= 1'b0;
      host_done   <= 1'b0;
      host_abort  <= 1'b0;
      host_wready <= 1'b0;
      host_rvalid <= 1'b0;
    end else begin
      state       <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      host_busy   <= busy_d;
      host_done   <= done_d;
      host_abort  <= abort_d;
      host_wready <= wready_d;
      host_rvalid <= rvalid_d;
    end
  end

  // Ownership mux and fixed-priority kernel arbiter.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = host_wdata;
    k_grant   = '0;
    found     = 1'b0;
    if (controlArr) begin
      mem_en = load_acc || dump_iss;
      mem_we = load_acc;
    end else begin
      for (int i = 0; i < int'(NPORT); i++) begin
        if (k_req[i] && !found) begin
          found      = 1'b1;
          k_grant[i] = 1'b1;
          mem_en     = 1'b1;
          mem_we     = k_we[i];
          mem_addr   = k_addr[i*ADDR_W +: ADDR_W];
          mem_wdata  = k_wdata[i*WIDTH +: WIDTH];
        end
      end
    end
    // Reset wins over any access attempted in the same cycle.
    mem_en = mem_en && rst_n;
  end

  // Kernel read-return flags track the previous cycle's read grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_rvalid_q <= '0;
    end else begin
      k_rvalid_q <= k_grant & ~k_we;
    end
  end

  assign k_rvalid   = k_rvalid_q & {NPORT{~controlArr}};
  assign k_rdata    = mem_rdata;
  assign host_rdata = mem_rdata;

  arr_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_arr_bank.sv
// Directed self-checking bench for arr_bank (WIDTH=64, DEPTH=16, NPORT=2).
// Inputs change at the falling edge; outputs are sampled 1 ns later.
module tb_arr_bank;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         controlArr;
  logic         host_start, host_mode;
  logic [3:0]   host_base;
  logic [4:0]   host_len;
  logic         host_wvalid, host_wready;
  logic [63:0]  host_wdata;
  logic         host_rvalid, host_rready;
  logic [63:0]  host_rdata;
  logic         host_busy, host_done, host_abort;
  logic [1:0]   k_req, k_we, k_grant, k_rvalid;
  logic [7:0]   k_addr;
  logic [127:0] k_wdata;
  logic [63:0]  k_rdata;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_w [3];

  always #5 clk = ~clk;

  arr_bank #(.WIDTH(64), .DEPTH(16), .NPORT(2)) dut (
    .clk(clk), .rst_n(rst_n), .controlArr(controlArr),
    .host_start(host_start), .host_mode(host_mode), .host_base(host_base),
    .host_len(host_len), .host_wvalid(host_wvalid), .host_wready(host_wready),
    .host_wdata(host_wdata), .host_rvalid(host_rvalid), .host_rready(host_rready),
    .host_rdata(host_rdata), .host_busy(host_busy), .host_done(host_done),
    .host_abort(host_abort), .k_req(k_req), .k_we(k_we), .k_addr(k_addr),
    .k_wdata(k_wdata), .k_grant(k_grant), .k_rvalid(k_rvalid), .k_rdata(k_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic kwrite(input logic [3:0] a, input logic [63:0] d);
    cyc(); k_req = 2'b01; k_we = 2'b01; k_addr[3:0] = a; k_wdata[63:0] = d;
    cyc(); k_req = 2'b00; k_we = 2'b00;
  endtask

  task automatic kread(input string tag, input logic [3:0] a, input logic [63:0] exp);
    cyc(); k_req = 2'b01; k_we = 2'b00; k_addr[3:0] = a;
    cyc(); k_req = 2'b00;
    #1;
    chk({tag, "_rvalid"}, 64'(k_rvalid), 64'h1);
    chk(tag, k_rdata, exp);
  endtask

  // Run one DUMP burst against exp_w, optionally stalling host_rready every other cycle.
  task automatic run_dump(input logic [3:0] base, input logic [4:0] len, input bit bp);
    int n = 0;
    int dn = 0;
    cyc(); host_start = 1'b1; host_mode = 1'b1; host_base = base; host_len = len;
    host_rready = 1'b0;
    cyc(); host_start = 1'b0;
    for (int c = 0; c < 24; c++) begin
      cyc();
      host_rready = bp ? c[0] : 1'b1;
      #1;
      if (host_rvalid && host_rready) begin
        if (n < int'(len)) chk("dump_data", host_rdata, exp_w[n]);
        else               chk("dump_extra_beat", 64'(n), 64'(len));
        n++;
      end
      if (host_done) dn++;
    end
    host_rready = 1'b0;
    chk("dump_beats", 64'(n), 64'(len));
    chk("dump_done_count", 64'(dn), 64'h1);
    chk("dump_idle_busy", 64'(host_busy), 64'h0);
  endtask

  initial begin
    rst_n = 1'b0; controlArr = 1'b0; host_start = 1'b0; host_mode = 1'b0;
    host_base = '0; host_len = '0; host_wvalid = 1'b0; host_wdata = '0;
    host_rready = 1'b0; k_req = '0; k_we = '0; k_addr = '0; k_wdata = '0;
    exp_w[0] = 64'd10; exp_w[1] = 64'd20; exp_w[2] = 64'd30;

    // Reset values
    cyc(); cyc(); #1;
    chk("rst_busy", 64'(host_busy), 0);
    chk("rst_done", 64'(host_done), 0);
    chk("rst_abort", 64'(host_abort), 0);
    chk("rst_wready", 64'(host_wready), 0);
    chk("rst_rvalid", 64'(host_rvalid), 0);
    chk("rst_k_rvalid", 64'(k_rvalid), 0);
    chk("rst_k_rdata", k_rdata, 0);
    chk("rst_host_rdata", host_rdata, 0);
    rst_n = 1'b1;

    // Kernel arbitration: port 0 writes 5 to addr 3, port 1 reads addr 3
    cyc(); k_req = 2'b11; k_we = 2'b01; k_addr = {4'd3, 4'd3}; k_wdata = {64'd0, 64'd5};
    #1 chk("arb_grant0", 64'(k_grant), 64'h1);
    cyc(); k_req = 2'b10; k_we = 2'b00;
    #1 chk("arb_grant1", 64'(k_grant), 64'h2);
    cyc(); k_req = 2'b00;
    #1 chk("arb_rvalid", 64'(k_rvalid), 64'h2);
    chk("arb_rdata", k_rdata, 64'h5);
    cyc(); #1 chk("arb_rvalid_clr", 64'(k_rvalid), 64'h0);

    // LOAD with wrap: base 14, len 4, data 1..4
    cyc(); controlArr = 1'b1; k_req = 2'b11;
    #1 chk("host_own_no_grant", 64'(k_grant), 64'h0);
    cyc(); k_req = 2'b00; host_start = 1'b1; host_mode = 1'b0; host_base = 4'd14; host_len = 5'd4;
    for (int i = 0; i < 4; i++) begin
      cyc(); host_start = 1'b0; host_wvalid = 1'b1; host_wdata = 64'(i + 1);
      #1 chk("load_wready", 64'(host_wready), 64'h1);
      chk("load_busy", 64'(host_busy), 64'h1);
      chk("load_no_done", 64'(host_done), 64'h0);
    end
    cyc(); host_wvalid = 1'b0;
    #1 chk("load_done", 64'(host_done), 64'h1);
    chk("load_busy_fall", 64'(host_busy), 64'h0);
    chk("load_wready_fall", 64'(host_wready), 64'h0);
    cyc(); #1 chk("load_done_pulse", 64'(host_done), 64'h0);
    cyc(); controlArr = 1'b0;
    #1 chk("load_no_abort", 64'(host_abort), 64'h0);
    kread("load_m14", 4'd14, 64'd1);
    kread("load_m15", 4'd15, 64'd2);
    kread("load_m0", 4'd0, 64'd3);
    kread("load_m1", 4'd1, 64'd4);
    kread("arb_m3_kept", 4'd3, 64'd5);

    // DUMP with backpressure
    kwrite(4'd0, 64'd10); kwrite(4'd1, 64'd20); kwrite(4'd2, 64'd30); kwrite(4'd10, 64'h77);
    cyc(); controlArr = 1'b1;
    run_dump(4'd0, 5'd3, 1'b1);

    // Zero-length burst
    cyc(); host_start = 1'b1; host_mode = 1'b0; host_base = 4'd0; host_len = 5'd0;
    host_wvalid = 1'b1; host_wdata = 64'hdead;
    cyc(); host_start = 1'b0;
    #1 chk("len0_busy", 64'(host_busy), 64'h1);
    chk("len0_no_done_early", 64'(host_done), 64'h0);
    chk("len0_wready1", 64'(host_wready), 64'h0);
    chk("len0_rvalid1", 64'(host_rvalid), 64'h0);
    cyc(); #1 chk("len0_done", 64'(host_done), 64'h1);
    chk("len0_wready2", 64'(host_wready), 64'h0);
    chk("len0_busy_fall", 64'(host_busy), 64'h0);
    cyc(); host_wvalid = 1'b0;
    #1 chk("len0_done_pulse", 64'(host_done), 64'h0);
    cyc(); controlArr = 1'b0;
    kread("len0_m0", 4'd0, 64'd10);

    // Abort after 2 of 5 LOAD beats
    cyc(); controlArr = 1'b1;
    cyc(); host_start = 1'b1; host_mode = 1'b0; host_base = 4'd8; host_len = 5'd5;
    cyc(); host_start = 1'b0; host_wvalid = 1'b1; host_wdata = 64'hA1;
    cyc(); host_wdata = 64'hA2;
    cyc(); host_wvalid = 1'b0; controlArr = 1'b0;
    k_req = 2'b01; k_we = 2'b00; k_addr[3:0] = 4'd8;
    #1 chk("abort_grant", 64'(k_grant), 64'h1);
    cyc(); k_req = 2'b00;
    #1 chk("abort_pulse", 64'(host_abort), 64'h1);
    chk("abort_no_done", 64'(host_done), 64'h0);
    chk("abort_busy", 64'(host_busy), 64'h0);
    chk("abort_k_rvalid", 64'(k_rvalid), 64'h1);
    chk("abort_m8", k_rdata, 64'hA1);
    cyc(); #1 chk("abort_pulse_clr", 64'(host_abort), 64'h0);
    chk("abort_done_still0", 64'(host_done), 64'h0);
    kread("abort_m9", 4'd9, 64'hA2);
    kread("abort_m10_kept", 4'd10, 64'h77);

    // Reset in the middle of a DUMP
    cyc(); controlArr = 1'b1;
    cyc(); host_start = 1'b1; host_mode = 1'b1; host_base = 4'd0; host_len = 5'd3; host_rready = 1'b1;
    cyc(); host_start = 1'b0;
    cyc(); #1 chk("rdump_first_valid", 64'(host_rvalid), 64'h1);
    chk("rdump_first_data", host_rdata, 64'd10);
    rst_n = 1'b0;
    cyc(); #1 chk("rdump_busy", 64'(host_busy), 0);
    chk("rdump_rvalid", 64'(host_rvalid), 0);
    chk("rdump_rdata", host_rdata, 0);
    chk("rdump_k_rdata", k_rdata, 0);
    chk("rdump_done", 64'(host_done), 0);
    chk("rdump_abort", 64'(host_abort), 0);
    rst_n = 1'b1;
    run_dump(4'd0, 5'd3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arr_bank.md
# arr_bank

Parametrised array-storage block for synthesised kernels: one single-ported RAM of DEPTH words × WIDTH bits, shared by NPORT kernel access ports under fixed-priority arbitration, plus a host burst engine that loads or dumps a contiguous address range over valid/ready streams. It replaces the fixed one-word array with a direct host address/data mux. The `controlArr` input selects the owner: host engine when high, kernel ports when low.

## Interface
- WIDTH, 64: data word width in bits
- DEPTH, 16: words in the array, ≥ 2
- ADDR_W, max(1, $clog2(DEPTH)): address width
- NPORT, 2: kernel access ports, 1..8

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- controlArr  in  1  1 = host owns the array, 0 = kernel owns it
- host_start  in  1  start pulse, sampled in IDLE only
- host_mode  in  1  0 = LOAD (host→array), 1 = DUMP (array→host)
- host_base  in  ADDR_W  first burst address
- host_len  in  ADDR_W+1  burst length in words, 0..DEPTH
- host_wvalid / host_wready  in / out  1  LOAD data handshake
- host_wdata  in  WIDTH  LOAD data
- host_rvalid / host_rready  out / in  1  DUMP data handshake
- host_rdata  out  WIDTH  DUMP data
- host_busy  out  1  engine not in IDLE
- host_done  out  1  one-cycle pulse, burst finished
- host_abort  out  1  one-cycle pulse, burst cancelled
- k_req  in  NPORT  per-port access request
- k_we  in  NPORT  per-port write enable
- k_addr  in  NPORT×ADDR_W  packed addresses, port i at [i*ADDR_W +: ADDR_W]
- k_wdata  in  NPORT×WIDTH  packed write data
- k_grant  out  NPORT  one-hot grant, combinational in the request cycle
- k_rvalid  out  NPORT  read data valid for port i, one cycle after its read grant
- k_rdata  out  WIDTH  shared read data

## Operation
- Reset values: host_busy, host_done, host_abort, host_wready, host_rvalid, k_grant, k_rvalid = 0; host_rdata, k_rdata = 0. The engine state is IDLE. Array contents are not cleared.
- Kernel side, active when controlArr = 0:
  - Grant goes to the lowest-index requesting port.
  - Ungranted ports must hold their request. No queueing inside the block.
  - Only one array access happens per cycle.
- Host FSM states:
  - IDLE: on host_start with controlArr = 1, latch base, len and mode. len = 0 goes to FIN. Otherwise host_mode selects LOAD or DUMP.
  - LOAD: host_wready = 1. Each accepted beat writes mem[addr]; addr ← (addr+1) mod DEPTH; count−1. After the last beat, go to FIN.
  - DUMP: issue a read whenever reads remain and the output slot will be free (slot empty, or host_rvalid & host_rready this cycle). The slot holds one word. When all words are issued and the slot has drained, go to FIN.
  - FIN: pulse host_done, then go to IDLE.
- Address wrap: base + len > DEPTH wraps modulo DEPTH. It is not an error.
- Abort: controlArr falling while busy returns the FSM to IDLE in the next cycle and pulses host_abort. host_done does not pulse. Writes already accepted remain in the array. Any pending host_rvalid is dropped.
- While controlArr = 1, all k_grant and k_rvalid are 0 and kernel requests are ignored.
- host_start outside IDLE is ignored.
- host_start with controlArr = 0 is ignored.

## Timing
- Read latency is 1 cycle, on both sides.
  - Read data is registered, so it is unaffected by a write in the following cycle.
  - A write in cycle t followed by a read of the same address in t+1 returns the new data in t+2.
- DUMP throughput with host_rready held high: first host_rvalid 2 cycles after host_start, then one word per cycle. host_done pulses 1 cycle after the last handshake.
- LOAD with host_wvalid held high: one word per cycle. host_done pulses the cycle after the last beat.
- host_busy rises in the cycle after host_start and falls with the host_done or host_abort pulse.
- rst_n low in any cycle forces reset values at the next edge. This takes priority over all handshakes.

## Structure
- Shared package `arr_pkg`:
  - typedef `host_state_t` with values IDLE, LOAD, DUMP, FIN
  - localparams HOST_LOAD = 1'b0, HOST_DUMP = 1'b1
  - function `arr_addr_w(depth)`
- Sub-module `arr_mem`: single-port RAM with registered read data, parametrised by WIDTH and DEPTH. Instantiated once.
- `arr_bank` contains the arbiter, the ownership mux and the host FSM.

## Test plan
- Kernel arbitration, WIDTH=64, DEPTH=16, NPORT=2: port 0 writes 0x5 to addr 3 while port 1 requests a read of addr 3. Expect k_grant=01, then 10 in the next cycle. Expect k_rvalid[1] with k_rdata=0x5 in the cycle after that.
- LOAD wrap: base=14, len=4, data 1,2,3,4. Expect mem[14,15,0,1] = 1,2,3,4 and host_done 4 cycles after the first beat is accepted.
- DUMP backpressure: dump base=0, len=3 of 10,20,30, with host_rready low on alternate cycles. Expect exactly 10,20,30 in order, no beat lost or duplicated, host_done once.
- len = 0: expect host_done 2 cycles after host_start, no host_wready or host_rvalid activity, and the array unchanged.
- Abort: drop controlArr after 2 of 5 LOAD beats. Expect host_abort, no host_done, only 2 words written, and kernel grants resume the next cycle.
- Reset mid-DUMP: assert rst_n=0 for 1 cycle. Expect all outputs 0 and IDLE; a new DUMP then returns the previously loaded data.
